// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: steps the register-file PC through instruction memory,
// assembles two bytes into a 16-bit instruction and services branch loads.
module fetch_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        branch_req,
  input  logic [7:0]  branch_addr,
  input  logic [7:0]  mem_data,
  input  logic        ir_ready,
  output logic [3:0]  arf_rsel,
  output logic [1:0]  arf_funsel,
  output logic [1:0]  arf_obsel,
  output logic [7:0]  arf_input,
  output logic        mem_en,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    FETCH_LO,
    FETCH_HI,
    HOLD,
    BRANCH
  } state_t;

  localparam logic [3:0] RSEL_NONE = 4'b0000;
  localparam logic [3:0] RSEL_PC   = 4'b1000;
  localparam logic [1:0] FUN_CLEAR = 2'b00;
  localparam logic [1:0] FUN_LOAD  = 2'b01;
  localparam logic [1:0] FUN_INC   = 2'b11;

  state_t state, state_next;
  logic   take_branch;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= CLR;
    else       state <= state_next;
  end

  // Branch requests are only honoured where the PC is idle; elsewhere they are dropped.
  assign take_branch = branch_req && (state == IDLE || state == HOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      ir        <= '0;
      arf_input <= '0;
    end else begin
      if (state == FETCH_LO) ir[7:0]  <= mem_data;
      if (state == FETCH_HI) ir[15:8] <= mem_data;
      if (take_branch)       arf_input <= branch_addr;
    end
  end

  // NOTE: every output of this block is given a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    arf_rsel   = RSEL_NONE;
    arf_funsel = FUN_CLEAR;
    arf_obsel  = 2'b11;
    mem_en     = 1'b0;
    ir_valid   = 1'b0;
    busy       = 1'b0;

    unique case (state)
      CLR: begin
        arf_rsel   = RSEL_PC;
        arf_funsel = FUN_CLEAR;
        busy       = 1'b1;
        state_next = IDLE;
      end
      IDLE: begin
        if (branch_req) state_next = BRANCH;
        else if (run)   state_next = FETCH_LO;
      end
      FETCH_LO: begin
        arf_rsel   = RSEL_PC;
        arf_funsel = FUN_INC;
        mem_en     = 1'b1;
        busy       = 1'b1;
        state_next = FETCH_HI;
      end
      FETCH_HI: begin
        arf_rsel   = RSEL_PC;
        arf_funsel = FUN_INC;
        mem_en     = 1'b1;
        busy       = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        ir_valid = 1'b1;
        if (branch_req)    state_next = BRANCH;
        else if (ir_ready) state_next = run ? FETCH_LO : IDLE;
      end
      BRANCH: begin
        arf_rsel   = RSEL_PC;
        arf_funsel = FUN_LOAD;
        busy       = 1'b1;
        state_next = run ? FETCH_LO : IDLE;
      end
      default: state_next = CLR;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; models the register-file PC and instruction memory.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset, run, branch_req, ir_ready;
  logic [7:0]  branch_addr, mem_data;
  logic [3:0]  arf_rsel;
  logic [1:0]  arf_funsel, arf_obsel;
  logic [7:0]  arf_input;
  logic        mem_en, ir_valid, busy;
  logic [15:0] ir;

  logic [7:0]  mem [256];
  logic [7:0]  pc;
  int          checks = 0;
  int          errors = 0;

  // Observed bundle: {rsel, funsel, mem_en, busy, ir_valid}
  localparam logic [8:0] O_CLR    = {4'b1000, 2'b00, 1'b0, 1'b1, 1'b0};
  localparam logic [8:0] O_IDLE   = {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [8:0] O_FETCH  = {4'b1000, 2'b11, 1'b1, 1'b1, 1'b0};
  localparam logic [8:0] O_HOLD   = {4'b0000, 2'b00, 1'b0, 1'b0, 1'b1};
  localparam logic [8:0] O_BRANCH = {4'b1000, 2'b01, 1'b0, 1'b1, 1'b0};

  fetch_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .branch_req  (branch_req),
    .branch_addr (branch_addr),
    .mem_data    (mem_data),
    .ir_ready    (ir_ready),
    .arf_rsel    (arf_rsel),
    .arf_funsel  (arf_funsel),
    .arf_obsel   (arf_obsel),
    .arf_input   (arf_input),
    .mem_en      (mem_en),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Register-file PC model: operation applied at the edge, visible next cycle.
  always @(posedge clock) begin
    if (arf_rsel[3]) begin
      case (arf_funsel)
        2'b00: pc <= 8'h00;
        2'b01: pc <= arf_input;
        2'b10: pc <= pc - 8'h01;
        2'b11: pc <= pc + 8'h01;
        default: pc <= pc;
      endcase
    end
  end

  assign mem_data = mem[pc];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_obs(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = {arf_rsel, arf_funsel, mem_en, busy, ir_valid};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_ir(input string name, input logic [15:0] exp);
    checks++;
    if (ir !== exp) begin
      errors++;
      $display("FAIL %s: ir got %h expected %h", name, ir, exp);
    end
  endtask

  task automatic check_pc(input string name, input logic [7:0] exp);
    checks++;
    if (pc !== exp) begin
      errors++;
      $display("FAIL %s: pc got %h expected %h", name, pc, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; branch_req = 1'b0; branch_addr = 8'h00; ir_ready = 1'b0;
    step(); step();
    check_obs("reset_outputs", O_CLR);
    check_ir("reset_ir", 16'h0000);
    checks++;
    if (arf_input !== 8'h00 || arf_obsel !== 2'b11) begin
      errors++;
      $display("FAIL reset_input_obsel: got %h/%b expected 00/11", arf_input, arf_obsel);
    end
    reset = 1'b0;
    step();
    check_obs("idle_after_reset", O_IDLE);
    check_pc("pc_cleared", 8'h00);
    step();
    check_obs("idle_stays", O_IDLE);
  endtask

  task automatic test_fetch();
    run = 1'b1; ir_ready = 1'b1;
    step(); check_obs("fetch_lo", O_FETCH);
    step(); check_obs("fetch_hi", O_FETCH); check_pc("pc_after_lo", 8'h01);
    step(); check_obs("hold1", O_HOLD); check_ir("ir1", 16'h3412); check_pc("pc_after_hi", 8'h02);
    step(); check_obs("throughput_fetch_lo", O_FETCH);
    step(); step();
    check_obs("hold2", O_HOLD); check_ir("ir2", 16'h7856); check_pc("pc_after_two", 8'h04);
    ir_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      step();
      check_obs("stall_outputs", O_HOLD);
      check_ir("stall_ir", 16'h7856);
    end
    ir_ready = 1'b1;
    step(); check_obs("release_fetch", O_FETCH); check_pc("release_pc", 8'h04);
    step(); step();
    check_obs("hold3", O_HOLD); check_ir("ir3", 16'hBC9A);
    ir_ready = 1'b0;
  endtask

  task automatic test_branch();
    branch_req = 1'b1; branch_addr = 8'h80;
    step();
    check_obs("branch_state", O_BRANCH);
    checks++;
    if (arf_input !== 8'h80) begin
      errors++;
      $display("FAIL branch_input: got %h expected 80", arf_input);
    end
    branch_req = 1'b0; branch_addr = 8'h00;
    step(); check_obs("branch_to_fetch", O_FETCH); check_pc("branch_pc", 8'h80);
    step(); step();
    check_obs("branch_hold", O_HOLD); check_ir("branch_ir", 16'h5AA5);
  endtask

  task automatic test_wrap();
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;
    branch_req = 1'b1; branch_addr = 8'hFE;
    step(); check_obs("wrap_branch", O_BRANCH);
    branch_req = 1'b0; ir_ready = 1'b1;
    step(); step(); step();
    check_obs("wrap_hold1", O_HOLD); check_ir("wrap_ir1", 16'hBBAA); check_pc("wrap_pc1", 8'h00);
    step(); step(); step();
    check_obs("wrap_hold2", O_HOLD); check_ir("wrap_ir2", 16'hDDCC); check_pc("wrap_pc2", 8'h02);
  endtask

  task automatic test_reset_mid();
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
    step(); step();
    check_obs("mid_fetch_hi", O_FETCH);
    reset = 1'b1;
    step();
    check_obs("mid_clr", O_CLR); check_ir("mid_ir_cleared", 16'h0000);
    reset = 1'b0;
    step(); check_obs("mid_idle", O_IDLE); check_pc("mid_pc_cleared", 8'h00);
    step(); step(); step();
    check_obs("mid_restart_hold", O_HOLD); check_ir("mid_restart_ir", 16'h3412);
    check_pc("mid_restart_pc", 8'h02);
  endtask

  task automatic test_run_low();
    run = 1'b0;
    step(); check_obs("run_low_idle", O_IDLE);
    ir_ready = 1'b0; run = 1'b1;
    step(); check_obs("ignore_fetch_lo", O_FETCH);
    branch_req = 1'b1; branch_addr = 8'h40;
    step(); check_obs("ignore_fetch_hi", O_FETCH);
    branch_req = 1'b0;
    step(); check_obs("ignore_hold", O_HOLD); check_ir("ignore_ir", 16'h7856);
    check_pc("ignore_pc", 8'h04);
    run = 1'b0; ir_ready = 1'b1;
    step(); check_obs("accept_to_idle", O_IDLE);
    branch_req = 1'b1; branch_addr = 8'h10;
    step(); check_obs("idle_branch", O_BRANCH);
    branch_req = 1'b0;
    step(); check_obs("idle_branch_back", O_IDLE); check_pc("idle_branch_pc", 8'h10);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
    mem[8'h04] = 8'h9A; mem[8'h05] = 8'hBC;
    mem[8'h80] = 8'hA5; mem[8'h81] = 8'h5A;
    test_reset();
    test_fetch();
    test_hold_stall();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_run_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
